// File: rtl/rst_seq_ctrl_if.sv
// Control and status signals of rst_seq_ctrl: LA-probe requests in, per-domain resets out.
// The watchdog pair exists only when RST_SEQ_WDOG_EN is defined.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              req_rst_i;
  logic              boot_sel_i;
  logic [NUM_CH-1:0] hold_mask_i;
  logic [NUM_CH-1:0] rst_n_o;
  logic              boot_sel_o;
  logic              done_o;
  logic              oeb_force_o;
  logic [1:0]        state_o;
`ifdef RST_SEQ_WDOG_EN
  logic              wdog_kick_i;
  logic              wdog_fired_o;

  modport master (
    output req_rst_i, boot_sel_i, hold_mask_i, wdog_kick_i,
    input  rst_n_o, boot_sel_o, done_o, oeb_force_o, state_o, wdog_fired_o
  );
  modport slave (
    input  req_rst_i, boot_sel_i, hold_mask_i, wdog_kick_i,
    output rst_n_o, boot_sel_o, done_o, oeb_force_o, state_o, wdog_fired_o
  );
`else
  modport master (
    output req_rst_i, boot_sel_i, hold_mask_i,
    input  rst_n_o, boot_sel_o, done_o, oeb_force_o, state_o
  );
  modport slave (
    input  req_rst_i, boot_sel_i, hold_mask_i,
    output rst_n_o, boot_sel_o, done_o, oeb_force_o, state_o
  );
`endif
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: settle count, staggered per-domain release, LA re-reset, hold masks, boot latch.
// Optional watchdog enabled by defining RST_SEQ_WDOG_EN.
module rst_seq_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned SYNC_STAGES = 2
`ifdef RST_SEQ_WDOG_EN
  , parameter int unsigned WDOG_W    = 16
`endif
) (
  input logic           ext_clk,
  input logic           ext_rst_n,
  rst_seq_ctrl_if.slave bus
);

  localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_COUNT   = 2'd1,
    S_STAGGER = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [NUM_CH-1:0]  passed_q, passed_d;
  logic [NUM_CH-1:0]  rst_n_q, rst_n_d;
  logic               boot_q, boot_d;
  logic               done_q, done_d;
  logic               oeb_q;
  logic [SYNC_STAGES-1:0] req_sync, boot_sync;
  logic               req_s, boot_s;
`ifdef RST_SEQ_WDOG_EN
  localparam logic [WDOG_W-1:0] WCNT_MAX = '1;
  logic [WDOG_W-1:0]  wcnt_q, wcnt_d;
  logic               fired_q, fired_d;
`endif

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign boot_s = boot_sync[SYNC_STAGES-1];

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      req_sync  <= '0;
      boot_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], bus.req_rst_i};
      boot_sync <= {boot_sync[SYNC_STAGES-2:0], bus.boot_sel_i};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    slot_d   = slot_q;
    passed_d = passed_q;
    boot_d   = boot_q;
`ifdef RST_SEQ_WDOG_EN
    wcnt_d   = wcnt_q;
    fired_d  = fired_q;
`endif
    unique case (state_q)
      S_RESET: begin
        if (!req_s) state_d = S_COUNT;
      end
      S_COUNT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = S_STAGGER;
          boot_d  = boot_s;
        end
      end
      S_STAGGER: begin
        if (gap_q == '0) passed_d[slot_q] = 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d  = '0;
          slot_d = slot_q + 1'b1;
        end else begin
          gap_d  = gap_q + 1'b1;
        end
        // Last release edge: park slot/gap so slot never runs past NUM_CH-1.
        if (gap_q == '0 && slot_q == SLOT_LAST) begin
          state_d = S_RUN;
          gap_d   = '0;
          slot_d  = slot_q;
        end
      end
      S_RUN: begin
`ifdef RST_SEQ_WDOG_EN
        if (bus.wdog_kick_i) begin
          wcnt_d = '0;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d = S_RESET;
          fired_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_RESET;
    endcase

    if (req_s && state_q != S_RESET) state_d = S_RESET;

    // Counters restart from zero whenever the sequence is (re)entered.
    if (state_d == S_RESET || state_d == S_COUNT) begin
      if (state_q != S_COUNT || state_d != S_COUNT) cnt_d = '0;
      gap_d    = '0;
      slot_d   = '0;
      passed_d = '0;
    end
    if (state_q == S_COUNT && state_d == S_STAGGER) begin
      cnt_d  = '0;
      gap_d  = '0;
      slot_d = '0;
    end
`ifdef RST_SEQ_WDOG_EN
    if (!(state_q == S_RUN && state_d == S_RUN)) wcnt_d = '0;
`endif

    rst_n_d = passed_d & ~bus.hold_mask_i;
    done_d  = (state_d == S_RUN);
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      gap_q    <= '0;
      slot_q   <= '0;
      passed_q <= '0;
      rst_n_q  <= '0;
      boot_q   <= 1'b0;
      done_q   <= 1'b0;
      oeb_q    <= 1'b1;
`ifdef RST_SEQ_WDOG_EN
      wcnt_q   <= '0;
      fired_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      slot_q   <= slot_d;
      passed_q <= passed_d;
      rst_n_q  <= rst_n_d;
      boot_q   <= boot_d;
      done_q   <= done_d;
      oeb_q    <= ~done_d;
`ifdef RST_SEQ_WDOG_EN
      wcnt_q   <= wcnt_d;
      fired_q  <= fired_d;
`endif
    end
  end

  assign bus.rst_n_o     = rst_n_q;
  assign bus.boot_sel_o  = boot_q;
  assign bus.done_o      = done_q;
  assign bus.oeb_force_o = oeb_q;
  assign bus.state_o     = state_q;
`ifdef RST_SEQ_WDOG_EN
  assign bus.wdog_fired_o = fired_q;
`endif

endmodule
